wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on posedge CLK.
REQ-002 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port wb_we, input, 1, pipeline writeback write enable; cannot be stalled.
REQ-004 SHALL have port wb_ra, input, 5, pipeline writeback destination register.
REQ-005 SHALL have port wb_wd, input, 32, pipeline writeback data.
REQ-006 SHALL have port md_valid, input, 1, multi-cycle unit (MDU) result valid.
REQ-007 SHALL have port md_ready, output, 1, arbiter accepts MDU result this cycle.
REQ-008 SHALL have port md_ra, input, 5, MDU destination register.
REQ-009 SHALL have port md_wd, input, 32, MDU result data.
REQ-010 SHALL have port md_issue, input, 1, MDU op issued; reserve md_issue_ra.
REQ-011 SHALL have port md_issue_ra, input, 5, register reserved by issued MDU op.
REQ-012 SHALL have ports qa1, qa2, input, 5 each, decode-stage source register queries.
REQ-013 SHALL have port hazard, output, 1, qa1 or qa2 is reserved (pending MDU write).
REQ-014 SHALL have ports rf_we/rf_ra/rf_wd, output, 1/5/32, to register file write port.
REQ-015 SHALL have port fifo_cnt, output, 2, MDU entries buffered (0..2).

Function
REQ-016 SHALL treat any write (WB or MDU) with register 0 as no-write: never asserts rf_we, occupies no port slot.
REQ-017 SHALL give WB absolute priority: effective wb_we=1 drives rf_we=1, rf_ra=wb_ra, rf_wd=wb_wd same cycle (combinational).
REQ-018 SHALL otherwise drive the rf port from FIFO head if fifo_cnt>0, popping it at posedge.
REQ-019 SHALL, when effective wb_we=0 and fifo_cnt=0 and md_valid=1, write MDU data directly to rf port same cycle (zero-latency bypass), no enqueue.
REQ-020 SHALL enqueue an accepted MDU result when the bypass is not taken; md_ready = (fifo_cnt<2); with push and pop in same cycle, fifo_cnt unchanged.
REQ-021 SHALL hold FIFO strictly in order; MDU writes reach rf in acceptance order.
REQ-022 SHALL keep a 32-bit busy vector: md_issue sets busy[md_issue_ra] at posedge (ignored for r0).
REQ-023 SHALL clear busy[r] at the posedge on which an MDU write to r is driven onto rf port (bypass or FIFO pop), not on acceptance.
REQ-024 SHALL, on simultaneous set and clear of the same register, leave busy set.
REQ-025 SHALL assert hazard = busy[qa1] | busy[qa2], combinational; busy[0] always 0.
REQ-026 SHALL require upstream never to issue to an already-busy register (WAW); arbiter behaviour then undefined, flagged by assertion.
REQ-027 SHALL not drop data: md_valid with md_ready=0 holds until accepted.

Reset
REQ-028 SHALL, while RST_N=0, clear FIFO (fifo_cnt=0), busy vector=0, and force rf_we=0, md_ready=0, hazard=0.
REQ-029 SHALL, on reset assertion mid-operation, discard buffered MDU results immediately; first posedge after deassertion sees empty state.

Structure
REQ-030 SHALL take REG_ADDR_W=5, DATA_W=32, WB_FIFO_DEPTH=2 from the shared CPU package.
REQ-031 SHALL implement buffering in one sub-module wb_fifo (2-entry, {ra,wd} entries, push/pop/count).

Verification
REQ-032 WB write r5=0x11 with md_valid r6=0x22, FIFO empty -> rf writes r5 this cycle, r6 next cycle, fifo_cnt 1 then 0.
REQ-033 FIFO idle, md_valid r7=0xAB, wb_we=0 -> rf_we=1 rf_ra=7 same cycle, fifo_cnt stays 0.
REQ-034 3 consecutive cycles wb_we=1 with md_valid -> md_ready drops after 2 accepts, fifo_cnt=2, order preserved on drain.
REQ-035 md_issue r9, qa1=9 -> hazard=1 until cycle r9 written to rf, then 0; wb_we to r0 -> rf_we=0 and FIFO drains instead.
REQ-036 RST_N low with fifo_cnt=2 and busy[9]=1 -> fifo_cnt=0, hazard=0, rf_we=0 immediately, no stale writes after release.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU parameters and types for the register-file write arbiter.
//   REG_ADDR_W / DATA_W   : register-file address and data widths
//   WB_FIFO_DEPTH         : number of MDU results that can wait for a free port
//   wb_entry_t            : one buffered MDU write {ra, wd}
//   rf_src_e              : which requester owns the register-file port this cycle
package wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned WB_FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W    = $clog2(WB_FIFO_DEPTH + 1);
  localparam int unsigned FIFO_PTR_W    = (WB_FIFO_DEPTH > 1) ? $clog2(WB_FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] ra;
    logic [DATA_W-1:0]     wd;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO,
    SRC_MDU
  } rf_src_e;

  // r0 is hardwired zero, so a write addressed to it is not a real write.
  function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] ra);
    return ra != '0;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: small in-order buffer for MDU results waiting on the RF write port.
//   CLK, RST_N : clock, asynchronous active-low reset (empties the buffer)
//   i_push     : store i_din at posedge (ignored when full)
//   i_pop      : drop the head entry at posedge (ignored when empty)
//   i_din      : entry to store
//   o_head     : oldest stored entry (valid when o_cnt != 0)
//   o_cnt      : number of stored entries
module wb_fifo
  import wb_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  wb_entry_t             i_din,
  output wb_entry_t             o_head,
  output logic [FIFO_CNT_W-1:0] o_cnt
);

  wb_entry_t             r_mem [WB_FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_CNT_W-1:0] r_cnt;
  logic                  w_push;
  logic                  w_pop;

  always_comb begin
    w_push = i_push && (r_cnt != FIFO_CNT_W'(WB_FIFO_DEPTH));
    w_pop  = i_pop  && (r_cnt != '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == FIFO_PTR_W'(WB_FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == FIFO_PTR_W'(WB_FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload storage needs no reset: r_cnt alone says which slots are valid.
  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the single register-file write port between the pipeline
// writeback stage (absolute priority, never stalled) and the multi-cycle unit.
// MDU results bypass straight to the port when it is idle, otherwise they wait
// in wb_fifo. A busy scoreboard tracks registers with an MDU write in flight
// and raises hazard for decode-stage source queries.
//   CLK, RST_N                  : clock, asynchronous active-low reset
//   wb_we, wb_ra, wb_wd         : writeback write request
//   md_valid/md_ready/md_ra/md_wd : MDU result handshake
//   md_issue, md_issue_ra       : MDU op issued, reserves destination register
//   qa1, qa2, hazard            : decode source queries and pending-write flag
//   rf_we, rf_ra, rf_wd         : register-file write port
//   fifo_cnt                    : buffered MDU results
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_ra,
  input  logic [DATA_W-1:0]     wb_wd,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_ra,
  input  logic [DATA_W-1:0]     md_wd,
  input  logic                  md_issue,
  input  logic [REG_ADDR_W-1:0] md_issue_ra,
  input  logic [REG_ADDR_W-1:0] qa1,
  input  logic [REG_ADDR_W-1:0] qa2,
  output logic                  hazard,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_ra,
  output logic [DATA_W-1:0]     rf_wd,
  output logic [1:0]            fifo_cnt
);

  logic [(1<<REG_ADDR_W)-1:0] r_busy;
  logic [(1<<REG_ADDR_W)-1:0] w_busy_nxt;
  rf_src_e                    w_src;
  wb_entry_t                  w_head;
  wb_entry_t                  w_din;
  logic [FIFO_CNT_W-1:0]      w_cnt;
  logic                       w_wb_real;
  logic                       w_md_real;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_waw;

  wb_fifo u_fifo (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_din  (w_din),
    .o_head (w_head),
    .o_cnt  (w_cnt)
  );

  always_comb begin
    w_wb_real = wb_we && is_real_reg(wb_ra);
    w_md_real = md_valid && is_real_reg(md_ra);
    md_ready  = RST_N && (w_cnt != FIFO_CNT_W'(WB_FIFO_DEPTH));

    // Buffered results drain before a new one may bypass, keeping MDU order.
    w_src = SRC_NONE;
    if (w_wb_real)
      w_src = SRC_WB;
    else if (w_cnt != '0)
      w_src = SRC_FIFO;
    else if (w_md_real)
      w_src = SRC_MDU;

    rf_we = RST_N && (w_src != SRC_NONE);
    rf_ra = '0;
    rf_wd = '0;
    case (w_src)
      SRC_WB:   begin rf_ra = wb_ra;     rf_wd = wb_wd;     end
      SRC_FIFO: begin rf_ra = w_head.ra; rf_wd = w_head.wd; end
      SRC_MDU:  begin rf_ra = md_ra;     rf_wd = md_wd;     end
      default:  begin rf_ra = '0;        rf_wd = '0;        end
    endcase

    w_pop    = (w_src == SRC_FIFO);
    // An r0 result is accepted but dropped; a bypassed one never enters the FIFO.
    w_push   = w_md_real && md_ready && (w_src != SRC_MDU);
    w_din.ra = md_ra;
    w_din.wd = md_wd;

    // Clear before set so an issue landing on the register being retired wins.
    w_busy_nxt = r_busy;
    if (w_src == SRC_FIFO || w_src == SRC_MDU)
      w_busy_nxt[rf_ra] = 1'b0;
    if (md_issue && is_real_reg(md_issue_ra))
      w_busy_nxt[md_issue_ra] = 1'b1;
    w_busy_nxt[0] = 1'b0;

    hazard = RST_N && (r_busy[qa1] || r_busy[qa2]);
    w_waw  = md_issue && is_real_reg(md_issue_ra) && r_busy[md_issue_ra];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_busy <= '0;
    else
      r_busy <= w_busy_nxt;
  end

  assign fifo_cnt = 2'(w_cnt);

  // Issuing to a register that still has an MDU write outstanding is illegal.
  a_no_waw: assert property (@(posedge CLK) disable iff (!RST_N) !w_waw);

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wb_we;
  logic [4:0]  wb_ra;
  logic [31:0] wb_wd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_ra;
  logic [31:0] md_wd;
  logic        md_issue;
  logic [4:0]  md_issue_ra;
  logic [4:0]  qa1;
  logic [4:0]  qa2;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_ra;
  logic [31:0] rf_wd;
  logic [1:0]  fifo_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  wb_arbiter dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .wb_we      (wb_we),
    .wb_ra      (wb_ra),
    .wb_wd      (wb_wd),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_ra      (md_ra),
    .md_wd      (md_wd),
    .md_issue   (md_issue),
    .md_issue_ra(md_issue_ra),
    .qa1        (qa1),
    .qa2        (qa2),
    .hazard     (hazard),
    .rf_we      (rf_we),
    .rf_ra      (rf_ra),
    .rf_wd      (rf_wd),
    .fifo_cnt   (fifo_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: pending MDU writes as an ordered queue, reservations as a
  // per-register flag set. Evaluated at negedge with inputs stable; after
  // evaluation the model holds the state the next posedge must produce.
  typedef struct {
    logic [4:0]  ra;
    logic [31:0] wd;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy[32];
  ent_t        m_e;
  logic        e_we, e_rdy, e_hz, byp;
  logic [4:0]  e_ra;
  logic [31:0] e_wd;
  logic [1:0]  e_cnt;

  always @(negedge CLK) begin
    e_we = 1'b0; e_ra = '0; e_wd = '0; byp = 1'b0;
    if (!RST_N) begin
      e_rdy = 1'b0; e_hz = 1'b0; e_cnt = '0;
      mq.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
    end else begin
      e_cnt = 2'(mq.size());
      e_rdy = (mq.size() < 2);
      e_hz  = m_busy[qa1] | m_busy[qa2];
      if (wb_we && wb_ra != 5'd0) begin
        e_we = 1'b1; e_ra = wb_ra; e_wd = wb_wd;
      end else if (mq.size() > 0) begin
        e_we = 1'b1; e_ra = mq[0].ra; e_wd = mq[0].wd;
        m_busy[e_ra] = 1'b0;
        mq.delete(0);
      end else if (md_valid && md_ra != 5'd0) begin
        e_we = 1'b1; e_ra = md_ra; e_wd = md_wd; byp = 1'b1;
        m_busy[md_ra] = 1'b0;
      end
      if (md_valid && e_rdy && md_ra != 5'd0 && !byp) begin
        m_e.ra = md_ra; m_e.wd = md_wd;
        mq.push_back(m_e);
      end
      if (md_issue && md_issue_ra != 5'd0) m_busy[md_issue_ra] = 1'b1;
    end
    chk("m_rf_we",    32'(rf_we),    32'(e_we));
    chk("m_md_ready", 32'(md_ready), 32'(e_rdy));
    chk("m_hazard",   32'(hazard),   32'(e_hz));
    chk("m_fifo_cnt", 32'(fifo_cnt), 32'(e_cnt));
    if (e_we) begin
      chk("m_rf_ra", 32'(rf_ra), 32'(e_ra));
      chk("m_rf_wd", rf_wd, e_wd);
    end
  end

  task automatic idle();
    wb_we = 0; wb_ra = 0; wb_wd = 0;
    md_valid = 0; md_ra = 0; md_wd = 0;
    md_issue = 0; md_issue_ra = 0;
    qa1 = 0; qa2 = 0;
  endtask

  task automatic nxt();
    @(posedge CLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 0; idle();
    wb_we = 1; wb_ra = 5'd3; wb_wd = 32'h33;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_md_ready", 32'(md_ready), 0);
    chk("rst_cnt", 32'(fifo_cnt), 0);
    @(posedge CLK); #1; RST_N = 1; idle();

    // zero-latency bypass
    md_valid = 1; md_ra = 5'd7; md_wd = 32'hAB;
    @(negedge CLK);
    chk("byp_we", 32'(rf_we), 1); chk("byp_ra", 32'(rf_ra), 7);
    chk("byp_wd", rf_wd, 32'hAB); chk("byp_cnt", 32'(fifo_cnt), 0);
    nxt(); idle();
    @(negedge CLK);
    chk("byp_cnt2", 32'(fifo_cnt), 0); chk("byp_we2", 32'(rf_we), 0);

    // WB priority, MDU deferred one cycle
    nxt();
    wb_we = 1; wb_ra = 5'd5; wb_wd = 32'h11; md_valid = 1; md_ra = 5'd6; md_wd = 32'h22;
    @(negedge CLK);
    chk("pri_ra", 32'(rf_ra), 5); chk("pri_wd", rf_wd, 32'h11); chk("pri_cnt", 32'(fifo_cnt), 0);
    nxt(); idle();
    @(negedge CLK);
    chk("def_cnt", 32'(fifo_cnt), 1); chk("def_we", 32'(rf_we), 1);
    chk("def_ra", 32'(rf_ra), 6); chk("def_wd", rf_wd, 32'h22);
    nxt();
    @(negedge CLK);
    chk("def_cnt2", 32'(fifo_cnt), 0); chk("def_we2", 32'(rf_we), 0);

    // fill FIFO under sustained WB, back-pressure, in-order drain
    nxt();
    wb_we = 1; wb_ra = 5'd1; wb_wd = 32'h1; md_valid = 1; md_ra = 5'd10; md_wd = 32'hA0;
    nxt();
    wb_ra = 5'd2; wb_wd = 32'h2; md_ra = 5'd11; md_wd = 32'hA1;
    @(negedge CLK); chk("fill_cnt1", 32'(fifo_cnt), 1);
    nxt();
    wb_ra = 5'd3; wb_wd = 32'h3; md_ra = 5'd12; md_wd = 32'hA2;
    @(negedge CLK);
    chk("full_cnt", 32'(fifo_cnt), 2); chk("full_rdy", 32'(md_ready), 0); chk("full_ra", 32'(rf_ra), 3);
    nxt(); wb_we = 0;
    @(negedge CLK);
    chk("drain0_ra", 32'(rf_ra), 10); chk("drain0_wd", rf_wd, 32'hA0); chk("drain0_rdy", 32'(md_ready), 0);
    nxt();
    @(negedge CLK);
    chk("drain1_ra", 32'(rf_ra), 11); chk("drain1_cnt", 32'(fifo_cnt), 1); chk("drain1_rdy", 32'(md_ready), 1);
    nxt(); md_valid = 0;
    @(negedge CLK);
    chk("drain2_ra", 32'(rf_ra), 12); chk("drain2_wd", rf_wd, 32'hA2); chk("drain2_cnt", 32'(fifo_cnt), 1);
    nxt();
    @(negedge CLK);
    chk("drain3_cnt", 32'(fifo_cnt), 0); chk("drain3_we", 32'(rf_we), 0);

    // reservation / hazard lifecycle, WB to r0 lets the FIFO drain
    nxt(); idle();
    md_issue = 1; md_issue_ra = 5'd9; qa1 = 5'd9;
    @(negedge CLK); chk("hz_pre", 32'(hazard), 0);
    nxt(); md_issue = 0;
    wb_we = 1; wb_ra = 5'd4; wb_wd = 32'h44; md_valid = 1; md_ra = 5'd9; md_wd = 32'h99;
    @(negedge CLK); chk("hz_set", 32'(hazard), 1);
    nxt(); wb_ra = 5'd0; wb_wd = 32'hDEAD; md_valid = 0;
    @(negedge CLK);
    chk("r0_we", 32'(rf_we), 1); chk("r0_ra", 32'(rf_ra), 9); chk("r0_wd", rf_wd, 32'h99);
    chk("hz_hold", 32'(hazard), 1);
    nxt(); wb_we = 0;
    @(negedge CLK); chk("hz_clr", 32'(hazard), 0); chk("hz_cnt", 32'(fifo_cnt), 0);

    // set and clear of the same register in one cycle: set wins
    nxt(); idle();
    md_valid = 1; md_ra = 5'd12; md_wd = 32'h5; md_issue = 1; md_issue_ra = 5'd12; qa2 = 5'd12;
    @(negedge CLK); chk("sc_hz0", 32'(hazard), 0);
    nxt(); md_issue = 0; md_wd = 32'h6;
    @(negedge CLK); chk("sc_hz1", 32'(hazard), 1); chk("sc_wd", rf_wd, 32'h6);
    nxt(); md_valid = 0;
    @(negedge CLK); chk("sc_hz2", 32'(hazard), 0);

    // MDU results to r0 are accepted and dropped
    nxt(); idle();
    md_valid = 1; md_ra = 5'd0; md_wd = 32'h77;
    @(negedge CLK); chk("md0_we", 32'(rf_we), 0); chk("md0_rdy", 32'(md_ready), 1);
    nxt(); wb_we = 1; wb_ra = 5'd1; wb_wd = 32'h8;
    nxt(); idle();
    @(negedge CLK); chk("md0_cnt", 32'(fifo_cnt), 0);

    // asynchronous reset with a full FIFO and a reservation outstanding
    nxt();
    md_issue = 1; md_issue_ra = 5'd9;
    nxt(); md_issue = 0;
    wb_we = 1; wb_ra = 5'd1; wb_wd = 32'h1; md_valid = 1; md_ra = 5'd9; md_wd = 32'h90;
    nxt(); wb_ra = 5'd2; md_ra = 5'd10; md_wd = 32'h91;
    nxt(); wb_ra = 5'd3; md_valid = 0; qa1 = 5'd9;
    @(negedge CLK); chk("pre_rst_cnt", 32'(fifo_cnt), 2); chk("pre_rst_hz", 32'(hazard), 1);
    @(posedge CLK); #2; RST_N = 0; #1;
    chk("arst_cnt", 32'(fifo_cnt), 0); chk("arst_hz", 32'(hazard), 0);
    chk("arst_we", 32'(rf_we), 0); chk("arst_rdy", 32'(md_ready), 0);
    @(posedge CLK); #1; RST_N = 1; idle(); qa1 = 5'd9;
    @(negedge CLK); chk("post_we", 32'(rf_we), 0); chk("post_cnt", 32'(fifo_cnt), 0);
    chk("post_hz", 32'(hazard), 0);
    nxt();
    @(negedge CLK); chk("post_we2", 32'(rf_we), 0);

    // mixed traffic soak checked by the model; never issues to a reserved register
    for (int i = 0; i < 400; i++) begin
      nxt();
      wb_we       = 1'($urandom_range(0, 2) == 0);
      wb_ra       = 5'($urandom_range(0, 31));
      wb_wd       = $urandom;
      md_valid    = 1'($urandom_range(0, 1));
      md_ra       = 5'($urandom_range(0, 31));
      md_wd       = $urandom;
      md_issue_ra = 5'($urandom_range(0, 31));
      md_issue    = 1'($urandom_range(0, 2) == 0) && !m_busy[md_issue_ra];
      qa1         = 5'($urandom_range(0, 31));
      qa2         = 5'($urandom_range(0, 31));
    end
    nxt(); idle();
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
